// File: rtl/bmem_arbiter_rr.sv
// bmem_arbiter_rr: N-client arbiter for the single burst-memory (bmem) port.
// Grants one client per transaction and holds the grant until the transaction
// completes: BURST_LEN write beats, or one read command followed by BURST_LEN
// returned beats. Returned read beats are steered to the current owner.
// Selection is round-robin starting at rr_ptr. Define ARB_FIXED_PRIO_EN to pin
// rr_ptr at 0, which gives strict lowest-index-first priority (client 0 =
// dcache, client 1 = icache).
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   client_read/client_write   per-client requests (write wins if both are set)
//   client_addr/client_wdata   packed per-client address / write beat
//   client_grant               one-hot owner, 0 in IDLE
//   client_ready               owner's read command or write beat accepted
//   client_rvalid/client_rdata read beat to owner / broadcast data
//   bmem_*                     memory side command, write and read-return bus
module bmem_arbiter_rr #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_LEN   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CLIENTS-1:0]            client_read,
  input  logic [NUM_CLIENTS-1:0]            client_write,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_wdata,
  output logic [NUM_CLIENTS-1:0]            client_grant,
  output logic [NUM_CLIENTS-1:0]            client_ready,
  output logic [NUM_CLIENTS-1:0]            client_rvalid,
  output logic [DATA_WIDTH-1:0]             client_rdata,
  input  logic                              bmem_ready,
  output logic                              bmem_read,
  output logic                              bmem_write,
  output logic [ADDR_WIDTH-1:0]             bmem_addr,
  output logic [DATA_WIDTH-1:0]             bmem_wdata,
  input  logic                              bmem_rvalid,
  input  logic [DATA_WIDTH-1:0]             bmem_rdata
);

  localparam int OW = $clog2(NUM_CLIENTS);
  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, READ_CMD, READ_DATA, WRITE} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]   owner_q, owner_d;

  logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0] addr_a;
  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] wdata_a;
  logic [NUM_CLIENTS-1:0]                 req;
  logic [NUM_CLIENTS-1:0]                 owner_oh;
  logic [OW-1:0]                          sel, cand;
  logic [OW-1:0]                          rr_next;
  logic                                   found;
  logic                                   last_beat;
  int                                     idx;

  assign addr_a    = client_addr;
  assign wdata_a   = client_wdata;
  assign req       = client_read | client_write;
  assign last_beat = (beat_cnt_q == BW'(BURST_LEN - 1));

`ifdef ARB_FIXED_PRIO_EN
  assign rr_next = '0;
`else
  assign rr_next = (owner_q == OW'(NUM_CLIENTS - 1)) ? '0 : owner_q + 1'b1;
`endif

  // First requester at or after rr_ptr, wrapping around the client set.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      cand = OW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    case (state_q)
      IDLE: if (found) begin
        owner_d    = sel;
        beat_cnt_d = '0;
        state_d    = client_write[sel] ? WRITE : READ_CMD;
      end
      READ_CMD: if (bmem_ready) begin
        beat_cnt_d = '0;
        state_d    = READ_DATA;
      end
      READ_DATA: if (bmem_rvalid) begin
        if (last_beat) begin
          beat_cnt_d = '0;
          rr_ptr_d   = rr_next;
          state_d    = IDLE;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      WRITE: if (bmem_ready) begin
        if (last_beat) begin
          beat_cnt_d = '0;
          rr_ptr_d   = rr_next;
          state_d    = IDLE;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
    end
  end

  // All outputs decode from registered state, so async reset zeroes them at once.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    client_grant      = '0;
    client_ready      = '0;
    client_rvalid     = '0;
    client_rdata      = '0;
    bmem_read         = 1'b0;
    bmem_write        = 1'b0;
    bmem_addr         = '0;
    bmem_wdata        = '0;
    case (state_q)
      READ_CMD: begin
        client_grant = owner_oh;
        bmem_read    = 1'b1;
        bmem_addr    = addr_a[owner_q];
        client_ready = bmem_ready ? owner_oh : '0;
      end
      READ_DATA: begin
        client_grant  = owner_oh;
        client_rvalid = bmem_rvalid ? owner_oh : '0;
        client_rdata  = bmem_rdata;
      end
      WRITE: begin
        client_grant = owner_oh;
        bmem_write   = 1'b1;
        bmem_addr    = addr_a[owner_q];
        bmem_wdata   = wdata_a[owner_q];
        client_ready = bmem_ready ? owner_oh : '0;
      end
      default: ;
    endcase
  end

endmodule
